// File: rtl/store_burst_pkg.sv
// Shared types and constants for the store burst controller and its data FIFO.
package store_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQUEST,
    TRANSFER,
    WAIT_DONE
  } burst_state_t;

  localparam int BEAT_BYTES = 4;
  localparam int LEN_WIDTH  = 8;

  // Address the next store must carry to extend the current burst; wraps at 32 bits.
  function automatic logic [31:0] next_word_address(input logic [31:0] base,
                                                    input logic [8:0]  count);
    return base + (32'(count) * 32'(BEAT_BYTES));
  endfunction

endpackage

// File: rtl/burst_data_fifo.sv
// Circular data buffer for collected stores: one write port, one registered read port,
// and a write-pointer rewind used to drop unvalidated entries on flush.
module burst_data_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pull_i,
  input  logic             rewind_i,
  input  logic [PTR_W-1:0] rewind_count_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    // Rewind wins over push so a flushed cycle never leaves a stale entry behind.
    if (rewind_i) begin
      wr_ptr_d = wr_ptr_q - rewind_count_i;
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pull_i) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rewind_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/store_burst_controller.sv
// Gathers committed stores to consecutive words and writes them out as one memory burst
// once every collected store has been validated by writeback.
module store_burst_controller
  import store_burst_pkg::*;
#(
  parameter int BUFFER_DEPTH = 16,
  parameter int MAX_BURST    = 16,
  parameter int TIMEOUT      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 st_valid_i,
  input  logic [31:0]          st_address_i,
  input  logic [31:0]          st_data_i,
  output logic                 st_ready_o,
  input  logic                 wb_valid_i,
  output logic                 mem_req_o,
  output logic [31:0]          mem_address_o,
  output logic [LEN_WIDTH-1:0] mem_burst_len_o,
  input  logic                 mem_req_ack_i,
  output logic [31:0]          mem_data_o,
  output logic                 mem_data_valid_o,
  output logic                 mem_data_last_o,
  input  logic                 mem_data_ready_i,
  input  logic                 mem_done_i,
  output logic                 idle_o
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam logic [8:0] MAX_COUNT   = 9'(MAX_BURST);
  localparam logic [5:0] TIMEOUT_CYC = 6'(TIMEOUT);

  burst_state_t state_q, state_d;
  logic [31:0]  base_q, base_d;
  logic [8:0]   count_q, count_d;
  logic [8:0]   validated_q, validated_d;
  logic [8:0]   beats_q, beats_d;
  logic [5:0]   timer_q, timer_d;
  logic         data_valid_q, data_valid_d;

  logic         push, pull, rewind;
  logic         consecutive, can_accept, close, last_beat;
  logic [31:0]  fifo_rd_data;

  assign consecutive = (st_address_i == next_word_address(base_q, count_q));
  assign can_accept  = (count_q < MAX_COUNT) && consecutive;
  assign close       = ((count_q == MAX_COUNT) || (st_valid_i && !consecutive) ||
                        (timer_q == TIMEOUT_CYC)) &&
                       (validated_q == count_q) && (count_q != 9'd0);
  assign last_beat   = (state_q == TRANSFER) && data_valid_q &&
                       (beats_q == count_q - 9'd1);

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    count_d         = count_q;
    validated_d     = validated_q;
    beats_d         = beats_q;
    timer_d         = timer_q;
    data_valid_d    = data_valid_q;
    push            = 1'b0;
    pull            = 1'b0;
    rewind          = 1'b0;
    st_ready_o      = 1'b0;
    mem_req_o       = 1'b0;
    mem_address_o   = '0;
    mem_burst_len_o = '0;

    unique case (state_q)
      IDLE: begin
        st_ready_o = 1'b1;
        if (st_valid_i && !flush_i) begin
          push        = 1'b1;
          base_d      = st_address_i;
          count_d     = 9'd1;
          validated_d = 9'd0;
          timer_d     = '0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        st_ready_o = can_accept;
        if (flush_i) begin
          count_d = validated_q;
          rewind  = 1'b1;
          timer_d = '0;
          if (validated_q == 9'd0) state_d = IDLE;
        end else begin
          push = st_valid_i && can_accept;
          if (push) begin
            count_d = count_q + 9'd1;
            timer_d = '0;
          end else if (timer_q < TIMEOUT_CYC) begin
            timer_d = timer_q + 6'd1;
          end
          if (wb_valid_i && (validated_q < count_q)) validated_d = validated_q + 9'd1;
          // A store accepted in the closing cycle would be unvalidated, so closing waits for it.
          if (close && !push) state_d = REQUEST;
        end
      end
      REQUEST: begin
        mem_req_o       = 1'b1;
        mem_address_o   = base_q;
        mem_burst_len_o = LEN_WIDTH'(count_q - 9'd1);
        if (mem_req_ack_i) begin
          pull         = 1'b1;
          data_valid_d = 1'b1;
          state_d      = TRANSFER;
        end
      end
      TRANSFER: begin
        if (data_valid_q && mem_data_ready_i) begin
          beats_d = beats_q + 9'd1;
          if (last_beat) begin
            data_valid_d = 1'b0;
            state_d      = WAIT_DONE;
          end else begin
            pull = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (mem_done_i) begin
          count_d     = 9'd0;
          validated_d = 9'd0;
          beats_d     = 9'd0;
          timer_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      base_q       <= '0;
      count_q      <= '0;
      validated_q  <= '0;
      beats_q      <= '0;
      timer_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      count_q      <= count_d;
      validated_q  <= validated_d;
      beats_q      <= beats_d;
      timer_q      <= timer_d;
      data_valid_q <= data_valid_d;
    end
  end

  burst_data_fifo #(
    .DEPTH(BUFFER_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .push_i        (push),
    .push_data_i   (st_data_i),
    .pull_i        (pull),
    .rewind_i      (rewind),
    .rewind_count_i(PTR_W'(count_q - validated_q)),
    .rd_data_o     (fifo_rd_data)
  );

  assign mem_data_valid_o = data_valid_q;
  assign mem_data_o       = data_valid_q ? fifo_rd_data : '0;
  assign mem_data_last_o  = last_beat;
  assign idle_o           = (state_q == IDLE) && (count_q == 9'd0);

endmodule

// File: tb/tb_store_burst_controller.sv
// Directed bench for store_burst_controller: burst assembly, close conditions, flush,
// back-pressure on the data channel and asynchronous reset mid-burst.
module tb_store_burst_controller;

  logic        clk_i;
  logic        rst_n_i;
  logic        flush_i;
  logic        st_valid_i;
  logic [31:0] st_address_i;
  logic [31:0] st_data_i;
  logic        st_ready_o;
  logic        wb_valid_i;
  logic        mem_req_o;
  logic [31:0] mem_address_o;
  logic [7:0]  mem_burst_len_o;
  logic        mem_req_ack_i;
  logic [31:0] mem_data_o;
  logic        mem_data_valid_o;
  logic        mem_data_last_o;
  logic        mem_data_ready_i;
  logic        mem_done_i;
  logic        idle_o;

  int vecCount;
  int missCount;
  bit readyPattern [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  store_burst_controller #(
    .BUFFER_DEPTH(16),
    .MAX_BURST   (16),
    .TIMEOUT     (32)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .flush_i         (flush_i),
    .st_valid_i      (st_valid_i),
    .st_address_i    (st_address_i),
    .st_data_i       (st_data_i),
    .st_ready_o      (st_ready_o),
    .wb_valid_i      (wb_valid_i),
    .mem_req_o       (mem_req_o),
    .mem_address_o   (mem_address_o),
    .mem_burst_len_o (mem_burst_len_o),
    .mem_req_ack_i   (mem_req_ack_i),
    .mem_data_o      (mem_data_o),
    .mem_data_valid_o(mem_data_valid_o),
    .mem_data_last_o (mem_data_last_o),
    .mem_data_ready_i(mem_data_ready_i),
    .mem_done_i      (mem_done_i),
    .idle_o          (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Offer one store and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    int n;
    st_valid_i   = 1'b1;
    st_address_i = addr;
    st_data_i    = data;
    #1;
    n = 0;
    while (!st_ready_o && n < 100) begin
      tick();
      #1;
      n++;
    end
    checkOutput("store_accept", st_ready_o, 1);
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic validate(input int times);
    for (int i = 0; i < times; i++) begin
      wb_valid_i = 1'b1;
      tick();
    end
    wb_valid_i = 1'b0;
  endtask

  task automatic waitReq();
    int n;
    n = 0;
    #1;
    while (!mem_req_o && n < 100) begin
      tick();
      #1;
      n++;
    end
    checkOutput("req_seen", mem_req_o, 1);
  endtask

  // Request handshake plus all data beats; ends in WAIT_DONE.
  task automatic drainBurst(input logic [31:0] addr, input int len,
                            input logic [31:0] data0, input bit toggle);
    int k;
    int guard;
    waitReq();
    checkOutput("req_addr", mem_address_o, addr);
    checkOutput("req_len", mem_burst_len_o, len);
    tick();
    #1;
    checkOutput("req_hold", mem_req_o, 1);
    checkOutput("req_hold_addr", mem_address_o, addr);
    checkOutput("req_hold_len", mem_burst_len_o, len);
    mem_req_ack_i = 1'b1;
    tick();
    mem_req_ack_i = 1'b0;
    checkOutput("req_drop", mem_req_o, 0);
    k = 0;
    guard = 0;
    while (k <= len && guard < 200) begin
      mem_data_ready_i = toggle ? readyPattern[guard % 5] : 1'b1;
      #1;
      checkOutput("beat_valid", mem_data_valid_o, 1);
      checkOutput("beat_data", mem_data_o, data0 + k);
      checkOutput("beat_last", mem_data_last_o, (k == len));
      if (mem_data_valid_o && mem_data_ready_i) k++;
      tick();
      guard++;
    end
    mem_data_ready_i = 1'b0;
    checkOutput("beat_count", k, len + 1);
    #1;
    checkOutput("valid_after_last", mem_data_valid_o, 0);
    checkOutput("idle_before_done", idle_o, 0);
  endtask

  task automatic finishBurst();
    mem_done_i = 1'b1;
    tick();
    mem_done_i = 1'b0;
    #1;
    checkOutput("idle_after_done", idle_o, 1);
  endtask

  initial begin
    vecCount         = 0;
    missCount        = 0;
    rst_n_i          = 1'b0;
    flush_i          = 1'b0;
    st_valid_i       = 1'b0;
    st_address_i     = '0;
    st_data_i        = '0;
    wb_valid_i       = 1'b0;
    mem_req_ack_i    = 1'b0;
    mem_data_ready_i = 1'b0;
    mem_done_i       = 1'b0;
    #1;
    checkOutput("rst_req", mem_req_o, 0);
    checkOutput("rst_valid", mem_data_valid_o, 0);
    checkOutput("rst_last", mem_data_last_o, 0);
    checkOutput("rst_st_ready", st_ready_o, 1);
    checkOutput("rst_idle", idle_o, 1);
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();

    // 1: four stores closed by the idle timeout
    for (int i = 0; i < 4; i++) applyStimulus(32'h100 + 4 * i, 32'hA000_0000 + i);
    validate(4);
    repeat (28) tick();
    #1;
    checkOutput("t1_no_early_req", mem_req_o, 0);
    tick();
    #1;
    checkOutput("t1_req_at_timeout", mem_req_o, 1);
    drainBurst(32'h100, 3, 32'hA000_0000, 1'b0);
    finishBurst();

    // 2: full burst closes without timeout; 17th store stalls
    for (int i = 0; i < 16; i++) applyStimulus(32'h1000 + 4 * i, 32'hB000_0000 + i);
    validate(16);
    st_valid_i   = 1'b1;
    st_address_i = 32'h1040;
    st_data_i    = 32'hB000_0100;
    #1;
    checkOutput("t2_full_stall", st_ready_o, 0);
    checkOutput("t2_no_req_yet", mem_req_o, 0);
    tick();
    #1;
    checkOutput("t2_req_immediate", mem_req_o, 1);
    checkOutput("t2_req_stall", st_ready_o, 0);
    drainBurst(32'h1000, 15, 32'hB000_0000, 1'b0);
    checkOutput("t2_wait_stall", st_ready_o, 0);
    finishBurst();
    checkOutput("t2_idle_accept", st_ready_o, 1);
    tick();
    st_valid_i = 1'b0;
    validate(1);
    drainBurst(32'h1040, 0, 32'hB000_0100, 1'b0);
    finishBurst();

    // 3: non-consecutive store closes the burst and opens the next one
    applyStimulus(32'h200, 32'hC000_0000);
    applyStimulus(32'h204, 32'hC000_0001);
    validate(2);
    st_valid_i   = 1'b1;
    st_address_i = 32'h300;
    st_data_i    = 32'hC300_0000;
    #1;
    checkOutput("t3_noncons_stall", st_ready_o, 0);
    tick();
    drainBurst(32'h200, 1, 32'hC000_0000, 1'b0);
    finishBurst();
    checkOutput("t3_idle_accept", st_ready_o, 1);
    tick();
    st_valid_i = 1'b0;
    validate(1);
    drainBurst(32'h300, 0, 32'hC300_0000, 1'b0);
    finishBurst();

    // 4: flush keeps validated entries, then flush with none validated
    for (int i = 0; i < 3; i++) applyStimulus(32'h400 + 4 * i, 32'hD000_0000 + i);
    validate(1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    checkOutput("t4_flush_keeps", idle_o, 0);
    drainBurst(32'h400, 0, 32'hD000_0000, 1'b0);
    finishBurst();
    applyStimulus(32'h500, 32'h5555_5555);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    checkOutput("t4_flush_to_idle", idle_o, 1);
    applyStimulus(32'h600, 32'h6666_6666);
    validate(1);
    drainBurst(32'h600, 0, 32'h6666_6666, 1'b0);
    finishBurst();

    // 5: data back-pressure with ready pattern 1,0,0,1,1
    for (int i = 0; i < 4; i++) applyStimulus(32'h700 + 4 * i, 32'hE000_0000 + i);
    validate(4);
    drainBurst(32'h700, 3, 32'hE000_0000, 1'b1);
    finishBurst();

    // 6: asynchronous reset in the middle of a transfer
    applyStimulus(32'h800, 32'hF000_0000);
    applyStimulus(32'h804, 32'hF000_0001);
    validate(2);
    waitReq();
    mem_req_ack_i = 1'b1;
    tick();
    mem_req_ack_i = 1'b0;
    #1;
    checkOutput("t6_in_transfer", mem_data_valid_o, 1);
    rst_n_i = 1'b0;
    #1;
    checkOutput("t6_rst_req", mem_req_o, 0);
    checkOutput("t6_rst_valid", mem_data_valid_o, 0);
    checkOutput("t6_rst_last", mem_data_last_o, 0);
    checkOutput("t6_rst_data", mem_data_o, 0);
    checkOutput("t6_rst_addr", mem_address_o, 0);
    repeat (2) tick();
    rst_n_i = 1'b1;
    #1;
    checkOutput("t6_st_ready", st_ready_o, 1);
    checkOutput("t6_idle", idle_o, 1);
    tick();
    applyStimulus(32'h900, 32'h9999_0000);
    validate(1);
    drainBurst(32'h900, 0, 32'h9999_0000, 1'b0);
    finishBurst();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
